// File: rtl/div.sv
// Shared divider types.
//   op_t : divide operation, OpDiv = signed, OpDivu = unsigned.
package div;

  typedef enum logic {
    OpDiv  = 1'b0,
    OpDivu = 1'b1
  } op_t;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: request/response sequencer in front of the iterative divider.
//
// Accepts one DIV/DIVU request at a time over req_valid/req_ready and latches its operands.
// It then pulses div_start for one cycle and waits for div_done. Finally it returns the
// quotient or remainder, with the request's tag, over resp_valid/resp_ready.
//
// Ports
//   clock, reset_n        : clock, asynchronous active-low reset
//   req_*                 : request channel (op, rem select, dividend, divisor, tag)
//   flush                 : abandon any pending/in-flight operation
//   resp_*                : response channel (data, tag)
//   div_op/div_start/...  : divider control and operands
//   div_done/div_q/div_r  : divider completion and results
//
// Build option
//   DIV_ZERO_BYPASS_EN : when defined, a zero divisor skips the divider entirely. The
//                        response is then ready one cycle after accept. Results are
//                        the same either way.
module div_ctrl #(
  parameter int unsigned DIVLEN = 32,
  parameter int unsigned TAGW   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  div::op_t          req_op,
  input  logic              req_rem,
  input  logic [DIVLEN-1:0] req_dividend,
  input  logic [DIVLEN-1:0] req_divisor,
  input  logic [TAGW-1:0]   req_tag,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DIVLEN-1:0] resp_data,
  output logic [TAGW-1:0]   resp_tag,
  output div::op_t          div_op,
  output logic              div_start,
  output logic [DIVLEN-1:0] div_dividend,
  output logic [DIVLEN-1:0] div_divisor,
  input  logic              div_done,
  input  logic [DIVLEN-1:0] div_q,
  input  logic [DIVLEN-1:0] div_r
);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StResp
  } state_e;

  state_e            state_q, state_d;
  div::op_t          op_q, op_d;
  logic              rem_q, rem_d;
  logic [DIVLEN-1:0] dividend_q, dividend_d;
  logic [DIVLEN-1:0] divisor_q, divisor_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [DIVLEN-1:0] resp_data_q, resp_data_d;
  logic [TAGW-1:0]   resp_tag_q, resp_tag_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rem_d       = rem_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    tag_d       = tag_q;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;

    if (flush) begin
      // Flush wins over every transition, including a same-cycle request.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_d       = req_op;
            rem_d      = req_rem;
            dividend_d = req_dividend;
            divisor_d  = req_divisor;
            tag_d      = req_tag;
`ifdef DIV_ZERO_BYPASS_EN
            if (req_divisor == '0) begin
              // Same result the divider produces for x/0, without starting it.
              state_d     = StResp;
              resp_data_d = req_rem ? req_dividend : '1;
              resp_tag_d  = req_tag;
            end else begin
              state_d = StStart;
            end
`else
            state_d = StStart;
`endif
          end
        end
        // div_done here still reflects the previous operation, so it is not looked at.
        StStart: state_d = StRun;
        StRun: begin
          if (div_done) begin
            resp_data_d = rem_q ? div_r : div_q;
            resp_tag_d  = tag_q;
            state_d     = StResp;
          end
        end
        StResp: begin
          if (resp_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      op_q        <= div::OpDiv;
      rem_q       <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      tag_q       <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      tag_q       <= tag_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

  // The state register idles on reset, so req_ready is gated with reset_n to stay low then.
  assign req_ready    = reset_n && (state_q == StIdle);
  assign resp_valid   = (state_q == StResp);
  assign resp_data    = resp_data_q;
  assign resp_tag     = resp_tag_q;
  assign div_start    = (state_q == StStart);
  assign div_op       = op_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl. Inputs are driven 1 time unit after the rising edge, and
// outputs are sampled on the falling edge. A behavioural divider answers div_start
// DIVLEN edges later and keeps div_done high until it is restarted. A scoreboard of
// expected responses is consumed by an independent monitor.
module tb_div_ctrl;

  localparam int unsigned DIVLEN = 32;
  localparam int unsigned TAGW   = 5;
  localparam int unsigned LAT    = DIVLEN + 3;
  localparam logic [DIVLEN-1:0] MinVal = {1'b1, {(DIVLEN - 1){1'b0}}};

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  div::op_t          req_op = div::OpDivu;
  logic              req_rem = 1'b0;
  logic [DIVLEN-1:0] req_dividend = '0;
  logic [DIVLEN-1:0] req_divisor = '0;
  logic [TAGW-1:0]   req_tag = '0;
  logic              flush = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DIVLEN-1:0] resp_data;
  logic [TAGW-1:0]   resp_tag;
  div::op_t          div_op;
  logic              div_start;
  logic [DIVLEN-1:0] div_dividend;
  logic [DIVLEN-1:0] div_divisor;
  logic              div_done = 1'b1;  // stale done from an imaginary earlier operation
  logic [DIVLEN-1:0] div_q = 32'hDEAD_BEEF;
  logic [DIVLEN-1:0] div_r = 32'hBAD0_BAD0;

  div_ctrl #(.DIVLEN(DIVLEN), .TAGW(TAGW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rem     (req_rem),
    .req_dividend(req_dividend),
    .req_divisor (req_divisor),
    .req_tag     (req_tag),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_tag    (resp_tag),
    .div_op      (div_op),
    .div_start   (div_start),
    .div_dividend(div_dividend),
    .div_divisor (div_divisor),
    .div_done    (div_done),
    .div_q       (div_q),
    .div_r       (div_r)
  );

  initial forever #5 clock = ~clock;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned starts = 0;
  int unsigned rr_mode = 0;  // 0: resp_ready=1, 1: random, 2: held low

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference divide: {quotient, remainder} with RISC-V style corner cases.
  function automatic logic [2*DIVLEN-1:0] ref_qr(input div::op_t op, input logic [DIVLEN-1:0] a,
                                                input logic [DIVLEN-1:0] b);
    logic signed [DIVLEN-1:0] sa, sb;
    logic [DIVLEN-1:0] q, r;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (op == div::OpDiv) begin
      if (a == MinVal && b == '1) begin
        q = MinVal;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Behavioural divider: result and done appear DIVLEN edges after the start edge.
  int unsigned dv_cnt = 0;
  bit dv_busy = 1'b0;
  always @(posedge clock) begin
    if (div_start) begin
      {div_q, div_r} <= ref_qr(div_op, div_dividend, div_divisor);
      div_done <= 1'b0;
      dv_busy  <= 1'b1;
      dv_cnt   <= DIVLEN - 1;
    end else if (dv_busy) begin
      if (dv_cnt == 0) begin
        div_done <= 1'b1;
        dv_busy  <= 1'b0;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'($urandom_range(0, 1));
      default: resp_ready = 1'b0;
    endcase
  end

  typedef struct {
    logic [DIVLEN-1:0] data;
    logic [TAGW-1:0]   tag;
    int unsigned       rise;
  } exp_t;
  exp_t sb[$];

  // Monitor: every cycle a response is shown it must match the oldest expectation.
  initial begin
    bit seen = 1'b0;
    bit ready_next = 1'b0;
    int unsigned rise = 0;
    forever begin
      @(negedge clock);
      if (div_start) starts++;
      if (!reset_n) begin
        seen = 1'b0;
        ready_next = 1'b0;
      end else begin
        if (ready_next && !flush) check("req_ready_after_handoff", 64'(req_ready), 64'd1);
        ready_next = 1'b0;
        if (resp_valid) begin
          if (!seen) begin
            seen = 1'b1;
            rise = cyc;
          end
          if (sb.size() == 0) begin
            check("spurious_resp_valid", 64'(resp_valid), 64'd0);
          end else begin
            check("resp_data", 64'(resp_data), 64'(sb[0].data));
            check("resp_tag", 64'(resp_tag), 64'(sb[0].tag));
            check("req_ready_in_resp", 64'(req_ready), 64'd0);
            if (resp_ready && !flush) begin
              check("resp_latency", 64'(rise), 64'(sb[0].rise));
              void'(sb.pop_front());
              seen = 1'b0;
              ready_next = 1'b1;
            end
          end
        end else begin
          seen = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a request until accepted; queue the expected response. Called at posedge+1.
  task automatic issue(input div::op_t op, input logic rem, input logic [DIVLEN-1:0] a,
                       input logic [DIVLEN-1:0] b, input logic [TAGW-1:0] tag,
                       input logic [DIVLEN-1:0] exp_data);
    int unsigned lat;
    bit acc, rdy;
    lat = LAT;
`ifdef DIV_ZERO_BYPASS_EN
    if (b == '0) lat = 1;
`endif
    acc = 1'b0;
    req_valid = 1'b1;
    req_op = op;
    req_rem = rem;
    req_dividend = a;
    req_divisor = b;
    req_tag = tag;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clock);
      rdy = req_ready && !flush;
      @(posedge clock);
      #1;
      acc = rdy;
    end
    req_valid = 1'b0;
    if (acc) sb.push_back('{exp_data, tag, cyc + lat - 1});
    else check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      check("response_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    step(1);
  endtask

  task automatic wait_resp_valid();
    int n = 0;
    while (!resp_valid && n < 200) begin
      step(1);
      n++;
    end
    if (!resp_valid) check("resp_valid_timeout", 64'(resp_valid), 64'd1);
  endtask

  function automatic logic [DIVLEN-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MinVal;
      3:       return DIVLEN'($urandom_range(1, 20));
      default: return DIVLEN'($urandom);
    endcase
  endfunction

  initial begin
    int unsigned s0;
    logic [2*DIVLEN-1:0] qr;
    div::op_t op;
    logic rem;
    logic [DIVLEN-1:0] a, b;

    // Reset values while reset_n is low.
    #2;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    step(3);
    reset_n = 1'b1;
    step(1);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Directed values; the divider's stale done is high during the first START.
    issue(div::OpDivu, 1'b0, 32'd100, 32'd7, 5'd1, 32'd14);
    wait_idle();
    issue(div::OpDivu, 1'b1, 32'd100, 32'd7, 5'd2, 32'd2);
    wait_idle();
    issue(div::OpDiv, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD);
    wait_idle();
    issue(div::OpDiv, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF);
    wait_idle();
    issue(div::OpDiv, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000);
    wait_idle();
    issue(div::OpDiv, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0);
    wait_idle();

    // Divide by zero, with the start-pulse count showing whether the divider was used.
    s0 = starts;
    issue(div::OpDivu, 1'b0, 32'h1234, 32'd0, 5'd7, 32'hFFFF_FFFF);
    wait_idle();
    issue(div::OpDivu, 1'b1, 32'h1234, 32'd0, 5'd8, 32'h1234);
    wait_idle();
`ifdef DIV_ZERO_BYPASS_EN
    check("div0_start_pulses", 64'(starts - s0), 64'd0);
`else
    check("div0_start_pulses", 64'(starts - s0), 64'd2);
`endif

    // Backpressure: resp_ready held low for 10 cycles of resp_valid.
    rr_mode = 2;
    step(1);
    issue(div::OpDivu, 1'b0, 32'd1000, 32'd10, 5'd9, 32'd100);
    wait_resp_valid();
    step(10);
    check("bp_resp_valid_held", 64'(resp_valid), 64'd1);
    rr_mode = 0;
    wait_idle();

    // Request together with flush is not accepted.
    req_valid = 1'b1;
    req_op = div::OpDivu;
    req_dividend = 32'd5;
    req_divisor = 32'd1;
    req_tag = 5'd10;
    flush = 1'b1;
    step(1);
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_req_no_start", 64'(div_start), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd1);

    // Flush in cycle 10 of RUN, then a new request.
    issue(div::OpDivu, 1'b0, 32'd77, 32'd3, 5'd11, 32'd25);
    step(11);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    sb.delete();
    check("flush_resp_valid", 64'(resp_valid), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd1);
    issue(div::OpDivu, 1'b0, 32'd9, 32'd3, 5'd12, 32'd3);
    wait_idle();
    step(40);  // the monitor flags any late response from the flushed tag

    // Reset during RUN.
    issue(div::OpDivu, 1'b0, 32'd50, 32'd5, 5'd13, 32'd10);
    step(6);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("rst_run_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_run_req_ready", 64'(req_ready), 64'd0);
    check("rst_run_div_start", 64'(div_start), 64'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("rst_run_release_ready", 64'(req_ready), 64'd1);
    issue(div::OpDiv, 1'b1, 32'hFFFF_FFEC, 32'd6, 5'd14, 32'hFFFF_FFFE);
    wait_idle();

    // Reset while a response is being held.
    rr_mode = 2;
    step(1);
    issue(div::OpDivu, 1'b0, 32'd21, 32'd4, 5'd15, 32'd5);
    wait_resp_valid();
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("rst_resp_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_resp_req_ready", 64'(req_ready), 64'd0);
    rr_mode = 0;
    step(2);
    reset_n = 1'b1;
    step(1);

    // Randomised traffic against the reference model, with random backpressure.
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 0) ? div::OpDiv : div::OpDivu;
      rem = 1'($urandom_range(0, 1));
      a = rand_opnd();
      b = rand_opnd();
      qr = ref_qr(op, a, b);
      issue(op, rem, a, b, TAGW'($urandom), rem ? qr[DIVLEN-1:0] : qr[2*DIVLEN-1:DIVLEN]);
    end
    wait_idle();
    rr_mode = 0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
